// File: rtl/snake_tick_scheduler_pkg.sv
// Shared definitions for the snake game-tick scheduler: state encodings,
// field widths and the per-level period helper.
package snake_tick_scheduler_pkg;

  localparam int LEVEL_W = 3;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  // Period in clkIn cycles for a speed level, in full 32-bit arithmetic.
  function automatic logic [CNT_W-1:0] period_for(
    input logic [LEVEL_W-1:0] lvl,
    input logic [CNT_W-1:0]   base,
    input logic [CNT_W-1:0]   step
  );
    logic [CNT_W-1:0] lvl_ext;
    lvl_ext = {{(CNT_W-LEVEL_W){1'b0}}, lvl};
    return base - (lvl_ext * step);
  endfunction

endpackage

// File: rtl/snake_tick_scheduler_tick_counter.sv
// Free-running period counter: counts while enabled and pulses terminal once
// the count reaches period-1 or beyond, wrapping to zero on that cycle.
module tick_counter
  import snake_tick_scheduler_pkg::*;
(
  input  logic             clkIn,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             terminal,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;
  logic             terminal_s;

  // A ">=" compare keeps the wrap safe when the period shrinks mid-count.
  always_comb begin
    terminal_s = 1'b0;
    if (enable && (count_r >= (period - 32'd1))) begin
      terminal_s = 1'b1;
    end else begin
      terminal_s = 1'b0;
    end
  end

  // Counter register: clear wins, then wrap on terminal, else count when enabled.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (terminal_s) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = terminal_s;
  assign count    = count_r;

endmodule

// File: rtl/snake_tick_scheduler.sv
// Programmable game-tick controller: speed levels, run/pause/stop control,
// held tick requests with acknowledge, and sticky overrun accounting.
module snake_tick_scheduler
  import snake_tick_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_0    = 32'd12587500,
  parameter int unsigned PERIOD_STEP = 32'd1573437,
  parameter int unsigned LEVELS      = 32'd8
) (
  input  logic               clkIn,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               speedUp,
  input  logic               speedReset,
  input  logic               clearStatus,
  input  logic               tickAck,
  output logic               tickReq,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               paused,
  output logic               overrun,
  output logic [7:0]         missedCount
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(LEVELS - 32'd1);

  state_e             state_r;
  logic               running_r;
  logic               paused_r;
  logic               tick_req_r;
  logic [LEVEL_W-1:0] level_r;
  logic               overrun_r;
  logic [7:0]         missed_r;

  logic [CNT_W-1:0]   period_s;
  logic               cnt_enable_s;
  logic               cnt_clear_s;
  logic               terminal_s;
  logic               accept_s;
  logic               miss_s;
  logic [LEVEL_W-1:0] level_next_s;
  logic [7:0]         missed_base_s;
  logic               overrun_base_s;
  logic [7:0]         missed_next_s;
  logic               overrun_next_s;

  assign period_s     = period_for(level_r, PERIOD_0, PERIOD_STEP);
  // stop suppresses counting, and therefore any tick, in the cycle it arrives
  assign cnt_enable_s = (state_r == ST_RUN) && !stop;
  assign cnt_clear_s  = stop || (state_r == ST_STOPPED);

  tick_counter u_tick_counter (
    .clkIn   (clkIn),
    .rst     (rst),
    .enable  (cnt_enable_s),
    .clear   (cnt_clear_s),
    .period  (period_s),
    .terminal(terminal_s),
    .count   ()
  );

  assign accept_s = terminal_s && (!tick_req_r || tickAck);
  assign miss_s   = terminal_s && tick_req_r && !tickAck;

  // Next speed level: reset beats step-up, step-up saturates at the top level.
  always_comb begin
    level_next_s = level_r;
    if (speedReset) begin
      level_next_s = {LEVEL_W{1'b0}};
    end else if (speedUp && (level_r != LEVEL_MAX)) begin
      level_next_s = level_r + 3'd1;
    end else begin
      level_next_s = level_r;
    end
  end

  // Status update: a clear is applied before a miss in the same cycle.
  always_comb begin
    missed_base_s  = missed_r;
    overrun_base_s = overrun_r;
    missed_next_s  = missed_r;
    overrun_next_s = overrun_r;
    if (clearStatus) begin
      missed_base_s  = 8'd0;
      overrun_base_s = 1'b0;
    end else begin
      missed_base_s  = missed_r;
      overrun_base_s = overrun_r;
    end
    if (miss_s) begin
      overrun_next_s = 1'b1;
      if (missed_base_s != 8'hFF) begin
        missed_next_s = missed_base_s + 8'd1;
      end else begin
        missed_next_s = missed_base_s;
      end
    end else begin
      overrun_next_s = overrun_base_s;
      missed_next_s  = missed_base_s;
    end
  end

  // Control FSM with registered running/paused flags.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      state_r   <= ST_STOPPED;
      running_r <= 1'b0;
      paused_r  <= 1'b0;
    end else if (stop) begin
      state_r   <= ST_STOPPED;
      running_r <= 1'b0;
      paused_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_STOPPED: begin
          if (start) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
            paused_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_r   <= ST_PAUSED;
            running_r <= 1'b0;
            paused_r  <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (pause) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
            paused_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_STOPPED;
          running_r <= 1'b0;
          paused_r  <= 1'b0;
        end
      endcase
    end
  end

  // Tick request handshake: a new tick beats a same-cycle ack, a miss holds it.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      tick_req_r <= 1'b0;
    end else if (cnt_clear_s) begin
      tick_req_r <= 1'b0;
    end else if (accept_s) begin
      tick_req_r <= 1'b1;
    end else if (tickAck) begin
      tick_req_r <= 1'b0;
    end else begin
      tick_req_r <= tick_req_r;
    end
  end

  // Level and status registers; the level survives stop but not reset.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      level_r   <= {LEVEL_W{1'b0}};
      overrun_r <= 1'b0;
      missed_r  <= 8'd0;
    end else begin
      level_r   <= level_next_s;
      overrun_r <= overrun_next_s;
      missed_r  <= missed_next_s;
    end
  end

  assign tickReq     = tick_req_r;
  assign level       = level_r;
  assign running     = running_r;
  assign paused      = paused_r;
  assign overrun     = overrun_r;
  assign missedCount = missed_r;

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Bench for snake_tick_scheduler: vector table, hand-built corner sequences
// and a randomized run against a cycle-level behavioural model.
module tb_snake_tick_scheduler;

  localparam int P0   = 10;
  localparam int STEP = 2;
  localparam int LV   = 4;

  localparam logic [7:0] C_RST   = 8'h80;
  localparam logic [7:0] C_START = 8'h40;
  localparam logic [7:0] C_STOP  = 8'h20;
  localparam logic [7:0] C_PAUSE = 8'h10;
  localparam logic [7:0] C_SU    = 8'h08;
  localparam logic [7:0] C_SR    = 8'h04;
  localparam logic [7:0] C_CLR   = 8'h02;
  localparam logic [7:0] C_ACK   = 8'h01;

  logic       clkIn = 1'b0;
  logic       rst = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic       speedUp = 1'b0, speedReset = 1'b0, clearStatus = 1'b0, tickAck = 1'b0;
  logic       tickReq, running, paused, overrun;
  logic [2:0] level;
  logic [7:0] missedCount;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_run, m_pause, m_req, m_ovr;
  int m_elapsed, m_level, m_missed;

  always #5 clkIn = ~clkIn;

  snake_tick_scheduler #(.PERIOD_0(P0), .PERIOD_STEP(STEP), .LEVELS(LV)) dut (
    .clkIn(clkIn), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .speedUp(speedUp), .speedReset(speedReset), .clearStatus(clearStatus),
    .tickAck(tickAck), .tickReq(tickReq), .level(level), .running(running),
    .paused(paused), .overrun(overrun), .missedCount(missedCount)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge of the game-tick rules, applied to the model.
  task automatic model_step(input logic [7:0] c);
    bit fire, miss, stopped;
    int per;
    if (c[7]) begin
      m_run = 0; m_pause = 0; m_req = 0; m_ovr = 0;
      m_elapsed = 0; m_level = 0; m_missed = 0;
      return;
    end
    per     = P0 - m_level * STEP;
    stopped = !m_run && !m_pause;
    fire    = m_run && !c[5] && (m_elapsed + 1 >= per);
    miss    = fire && m_req && !c[0];
    if (c[5] || stopped) m_req = 0;
    else if (fire && !miss) m_req = 1;
    else if (c[0]) m_req = 0;
    if (c[5] || stopped || fire) m_elapsed = 0;
    else if (m_run) m_elapsed = m_elapsed + 1;
    if (c[1]) begin m_missed = 0; m_ovr = 0; end
    if (miss) begin
      m_ovr = 1;
      if (m_missed < 255) m_missed = m_missed + 1;
    end
    if (c[2]) m_level = 0;
    else if (c[3] && m_level < LV - 1) m_level = m_level + 1;
    if (c[5]) begin m_run = 0; m_pause = 0; end
    else if (stopped) m_run = c[6];
    else if (c[4]) begin m_run = !m_run; m_pause = !m_pause; end
  endtask

  task automatic check_model();
    cmp("model.tickReq", tickReq, m_req);
    cmp("model.level", level, m_level);
    cmp("model.running", running, m_run);
    cmp("model.paused", paused, m_pause);
    cmp("model.overrun", overrun, m_ovr);
    cmp("model.missedCount", missedCount, m_missed);
  endtask

  task automatic step(input logic [7:0] c);
    {rst, start, stop, pause, speedUp, speedReset, clearStatus, tickAck} = c;
    @(posedge clkIn);
    model_step(c);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(8'h00);
  endtask

  task automatic chk(input string tag, input logic req, input int lvl, input logic run,
                     input logic pau, input logic ovr, input int mis);
    cmp({tag, ".tickReq"}, tickReq, req);
    cmp({tag, ".level"}, level, lvl);
    cmp({tag, ".running"}, running, run);
    cmp({tag, ".paused"}, paused, pau);
    cmp({tag, ".overrun"}, overrun, ovr);
    cmp({tag, ".missedCount"}, missedCount, mis);
  endtask

  typedef struct {
    logic [7:0] ctrl;
    int         n;
    logic       req;
    int         lvl;
    logic       run;
    logic       pau;
    logic       ovr;
    int         mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] c, input int n, input logic req, input int lvl,
                              input logic run, input logic pau, input logic ovr, input int mis);
    vec_t v;
    v.ctrl = c; v.n = n; v.req = req; v.lvl = lvl;
    v.run = run; v.pau = pau; v.ovr = ovr; v.mis = mis;
    return v;
  endfunction

  initial begin
    logic [7:0] c;

    // rows: inputs for one cycle, then n-1 idle cycles, then expected outputs
    tbl.push_back(mk(C_RST,        1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(C_START,      1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        9, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        2, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(C_ACK,        1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        6, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,       10, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(8'h00,       10, 1, 0, 1, 0, 1, 2));
    tbl.push_back(mk(C_CLR,        1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(C_STOP,       1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU | C_SR,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(C_SU,         1, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(C_START,      1, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        3, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        1, 1, 3, 1, 0, 0, 0));
    tbl.push_back(mk(C_ACK,        1, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00,        3, 1, 3, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].ctrl);
      idle(tbl[i].n - 1);
      chk($sformatf("row%0d", i), tbl[i].req, tbl[i].lvl, tbl[i].run,
          tbl[i].pau, tbl[i].ovr, tbl[i].mis);
    end

    // level jumps to 3 while frozen at count 7: tick on the first resumed cycle
    step(C_RST); step(C_START); idle(6);
    step(C_PAUSE);              chk("lvljump.paused", 0, 0, 0, 1, 0, 0);
    step(C_SU); step(C_SU); step(C_SU);
    step(C_PAUSE);              chk("lvljump.resume", 0, 3, 1, 0, 0, 0);
    step(8'h00);                chk("lvljump.tick", 1, 3, 1, 0, 0, 0);
    step(C_ACK); idle(2);       chk("lvljump.gap", 0, 3, 1, 0, 0, 0);
    step(8'h00);                chk("lvljump.next", 1, 3, 1, 0, 0, 0);

    // pause freezes the count at 5, ack honoured while paused, tick 5 after resume
    step(C_RST); step(C_START); idle(14);
    chk("pause.pre", 1, 0, 1, 0, 0, 0);
    step(C_PAUSE);              chk("pause.enter", 1, 0, 0, 1, 0, 0);
    idle(4);                    chk("pause.hold", 1, 0, 0, 1, 0, 0);
    step(C_ACK);                chk("pause.ack", 0, 0, 0, 1, 0, 0);
    idle(15);                   chk("pause.noTick", 0, 0, 0, 1, 0, 0);
    step(C_PAUSE);              chk("pause.resume", 0, 0, 1, 0, 0, 0);
    idle(4);                    chk("pause.before", 0, 0, 1, 0, 0, 0);
    step(8'h00);                chk("pause.tick", 1, 0, 1, 0, 0, 0);

    // stop beats start/pause; level retained; rst in mid-run clears everything
    step(C_RST); step(C_SU); step(C_SU); step(C_START); idle(5);
    chk("stop.before", 0, 2, 1, 0, 0, 0);
    step(8'h00);                chk("stop.tick", 1, 2, 1, 0, 0, 0);
    step(C_STOP | C_START | C_PAUSE);
    chk("stop.prio", 0, 2, 0, 0, 0, 0);
    step(C_START); idle(5);     chk("stop.restart", 0, 2, 1, 0, 0, 0);
    step(8'h00);                chk("stop.tick2", 1, 2, 1, 0, 0, 0);
    idle(6);                    chk("stop.miss", 1, 2, 1, 0, 1, 1);
    step(C_RST);                chk("rst.midrun", 0, 0, 0, 0, 0, 0);

    // missedCount saturation, then clear coinciding with a miss
    step(C_RST); step(C_SU); step(C_SU); step(C_SU); step(C_START);
    idle(1202);                 chk("sat.255", 1, 3, 1, 0, 1, 255);
    step(8'h00);                chk("sat.hold", 1, 3, 1, 0, 1, 255);
    step(C_CLR);                chk("sat.clrMiss", 1, 3, 1, 0, 1, 1);
    step(C_CLR);                chk("sat.clr", 1, 3, 1, 0, 0, 0);

    // randomized control traffic against the model
    step(C_RST);
    for (int k = 0; k < 4000; k++) begin
      c = 8'h00;
      c[7] = ($urandom_range(0, 499) == 0);
      c[6] = ($urandom_range(0, 9) == 0);
      c[5] = ($urandom_range(0, 79) == 0);
      c[4] = ($urandom_range(0, 24) == 0);
      c[3] = ($urandom_range(0, 29) == 0);
      c[2] = ($urandom_range(0, 59) == 0);
      c[1] = ($urandom_range(0, 39) == 0);
      c[0] = ($urandom_range(0, 4) == 0);
      step(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
